// File: rtl/pu_pkg.sv
// Shared types and default parameter values for the pu_seq instruction sequencer.
package pu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } pu_state_e;

    localparam int          IW_DEF     = 16;
    localparam int          PCW_DEF    = 8;
    localparam int          DEPTH_DEF  = 4;
    localparam int unsigned RST_PC_DEF = 0;

endpackage

// File: rtl/pu_stk.sv
// Return-address stack for pu_seq: LIFO of PCW-bit addresses, DEPTH entries.
module pu_stk #(
    parameter int PCW   = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [PCW-1:0] din_i,
    output logic [PCW-1:0] top_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PCW-1:0] mem_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] top_idx;

    assign wr_idx  = IDXW'(sp_q);
    assign top_idx = IDXW'(sp_q - SPW'(1));
    assign full_o  = (sp_q == SPW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_o   = empty_o ? '0 : mem_q[top_idx];

    // Push and pop are exclusive requests; a request against full/empty is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            mem_q[wr_idx] <= din_i;
            sp_q          <= sp_q + SPW'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

endmodule

// File: rtl/pu_seq.sv
// Instruction sequencer: fetch handshake, exec wait, PC update with call/return stack.
//   state | meaning
//   FETCH | imem_req high, wait for imem_ack, capture instruction
//   EXEC  | wait for ex_done, then apply one PC update
//   HALT  | stopped (halt request or stack fault) until rst
module pu_seq
    import pu_pkg::*;
#(
    parameter int          IW     = IW_DEF,
    parameter int          PCW    = PCW_DEF,
    parameter int          DEPTH  = DEPTH_DEF,
    parameter int unsigned RST_PC = RST_PC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    output logic           imem_req,
    output logic [PCW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [IW-1:0]  imem_rdata,
    output logic [IW-1:0]  ir,
    output logic           ir_valid,
    input  logic           ex_done,
    input  logic           jmp,
    input  logic           call,
    input  logic           ret,
    input  logic           halt,
    input  logic [PCW-1:0] jmp_addr,
    output logic [PCW-1:0] pc,
    output logic           halted,
    output logic           err
);

    pu_state_e      state_q;
    logic [PCW-1:0] pc_q;
    logic [IW-1:0]  ir_q;
    logic           ir_valid_q;
    logic           halted_q;
    logic           err_q;

    logic           done_ex;
    logic           stk_push;
    logic           stk_pop;
    logic           stk_full;
    logic           stk_empty;
    logic [PCW-1:0] stk_top;
    logic [PCW-1:0] pc_inc;

    assign pc_inc   = pc_q + PCW'(1);
    assign done_ex  = (state_q == EXEC) && ex_done;
    assign stk_pop  = done_ex && !halt && ret;
    assign stk_push = done_ex && !halt && !ret && call;

    pu_stk #(
        .PCW   (PCW),
        .DEPTH (DEPTH)
    ) u_stk (
        .clk     (clk),
        .rst     (rst),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .din_i   (pc_inc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // Gated by rst so the request drops in the same cycle reset is raised.
    assign imem_req  = (state_q == FETCH) && !rst;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = halted_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= PCW'(RST_PC);
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ir_valid_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        ir_valid_q <= 1'b1;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    if (ex_done) begin
                        if (halt) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else if (ret) begin
                            if (stk_empty) begin
                                err_q    <= 1'b1;
                                halted_q <= 1'b1;
                                state_q  <= HALT;
                            end else begin
                                pc_q    <= stk_top;
                                state_q <= FETCH;
                            end
                        end else if (call) begin
                            if (stk_full) begin
                                err_q    <= 1'b1;
                                halted_q <= 1'b1;
                                state_q  <= HALT;
                            end else begin
                                pc_q    <= jmp_addr;
                                state_q <= FETCH;
                            end
                        end else if (jmp) begin
                            pc_q    <= jmp_addr;
                            state_q <= FETCH;
                        end else begin
                            pc_q    <= pc_inc;
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_seq.sv
// Directed bench for pu_seq: fetch/exec timing, wrap, call/ret stack, faults, reset.
module tb_pu_seq;

    localparam int IW  = 16;
    localparam int PCW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_ack = 1'b0;
    logic [IW-1:0]  imem_rdata = '0;
    logic [IW-1:0]  ir;
    logic           ir_valid;
    logic           ex_done = 1'b0;
    logic           jmp = 1'b0;
    logic           call = 1'b0;
    logic           ret = 1'b0;
    logic           halt = 1'b0;
    logic [PCW-1:0] jmp_addr = '0;
    logic [PCW-1:0] pc;
    logic           halted;
    logic           err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [IW-1:0] last_ir = '0;

    pu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ex_done    (ex_done),
        .jmp        (jmp),
        .call       (call),
        .ret        (ret),
        .halt       (halt),
        .jmp_addr   (jmp_addr),
        .pc         (pc),
        .halted     (halted),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        ex_done = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_ctl();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_req",    32'(imem_req), 0);
        check_eq("rst_pc",     32'(pc), 0);
        check_eq("rst_ir",     32'(ir), 0);
        check_eq("rst_irv",    32'(ir_valid), 0);
        check_eq("rst_halted", 32'(halted), 0);
        check_eq("rst_err",    32'(err), 0);
        rst = 1'b0;
        last_ir = '0;
        #1;
        check_eq("post_rst_req", 32'(imem_req), 1);
    endtask

    // Called at a negedge while in FETCH; returns at the negedge after the ex_done edge.
    task automatic run_instr(input logic [7:0] exp_pc, input logic [15:0] instr,
                             input int waits, input int ex_waits,
                             input logic j, input logic c, input logic r, input logic h,
                             input logic [7:0] tgt);
        check_eq("fetch_req",  32'(imem_req), 1);
        check_eq("fetch_addr", 32'(imem_addr), 32'(exp_pc));
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0; imem_rdata = 16'hDEAD;
            @(negedge clk);
            check_eq("wait_addr", 32'(imem_addr), 32'(exp_pc));
            check_eq("wait_req",  32'(imem_req), 1);
            check_eq("wait_ir",   32'(ir), 32'(last_ir));
        end
        imem_ack = 1'b1; imem_rdata = instr;
        @(negedge clk);
        imem_rdata = 16'hBEEF;
        check_eq("exec_irv", 32'(ir_valid), 1);
        check_eq("exec_ir",  32'(ir), 32'(instr));
        check_eq("exec_req", 32'(imem_req), 0);
        check_eq("exec_pc",  32'(pc), 32'(exp_pc));
        last_ir = instr;
        for (int i = 0; i < ex_waits; i++) begin
            ex_done = 1'b0; jmp = 1'b1; jmp_addr = 8'h99;
            @(negedge clk);
            check_eq("exwait_irv", 32'(ir_valid), 0);
            check_eq("exwait_req", 32'(imem_req), 0);
            check_eq("exwait_pc",  32'(pc), 32'(exp_pc));
            check_eq("exwait_ir",  32'(ir), 32'(instr));
        end
        imem_ack = 1'b0;
        ex_done = 1'b1; jmp = j; call = c; ret = r; halt = h; jmp_addr = tgt;
        @(negedge clk);
        clear_ctl();
        check_eq("post_irv", 32'(ir_valid), 0);
    endtask

    task automatic hammer_halted(input int n, input logic [7:0] exp_pc, input logic exp_err);
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'b1; imem_rdata = 16'h5A5A;
            ex_done = 1'b1; jmp = 1'b1; call = (i % 2) == 0; ret = (i % 2) == 1;
            halt = (i == 2); jmp_addr = 8'hC3;
            @(negedge clk);
            check_eq("halt_pc",  32'(pc), 32'(exp_pc));
            check_eq("halt_h",   32'(halted), 1);
            check_eq("halt_err", 32'(err), 32'(exp_err));
            check_eq("halt_req", 32'(imem_req), 0);
            check_eq("halt_irv", 32'(ir_valid), 0);
            check_eq("halt_ir",  32'(ir), 32'(last_ir));
        end
        clear_ctl();
    endtask

    initial begin
        do_reset();

        // Back-to-back sequential instructions, ex_done coincident with ir_valid.
        for (int i = 0; i < 4; i++) begin
            run_instr(8'(i), 16'h1000 + 16'(i), 0, 0, 0, 0, 0, 0, 8'h00);
            check_eq("seq_pc", 32'(pc), 32'(i + 1));
        end
        run_instr(8'h04, 16'h1004, 0, 0, 0, 0, 0, 0, 8'h00);
        check_eq("seq_pc4", 32'(pc), 32'h05);
        run_instr(8'h05, 16'h1005, 3, 0, 0, 0, 0, 0, 8'h00);
        check_eq("wait_pc5", 32'(pc), 32'h06);
        run_instr(8'h06, 16'h2006, 0, 2, 1, 0, 0, 0, 8'hFF);
        check_eq("jmp_ff", 32'(pc), 32'hFF);
        run_instr(8'hFF, 16'h10FF, 0, 0, 0, 0, 0, 0, 8'h00);
        check_eq("wrap", 32'(pc), 32'h00);

        // Call/return, including ret+call together (ret wins).
        run_instr(8'h00, 16'h2000, 0, 0, 1, 0, 0, 0, 8'h10);
        check_eq("jmp_10", 32'(pc), 32'h10);
        run_instr(8'h10, 16'h3010, 0, 0, 0, 1, 0, 0, 8'h40);
        check_eq("call_40", 32'(pc), 32'h40);
        run_instr(8'h40, 16'h4040, 0, 0, 0, 1, 1, 0, 8'h55);
        check_eq("ret_11", 32'(pc), 32'h11);
        run_instr(8'h11, 16'h3011, 0, 0, 0, 1, 0, 0, 8'h20);
        run_instr(8'h20, 16'h3020, 0, 0, 1, 1, 0, 0, 8'h30);
        check_eq("call2", 32'(pc), 32'h30);
        run_instr(8'h30, 16'h4030, 0, 0, 0, 0, 1, 0, 8'h00);
        check_eq("ret_21", 32'(pc), 32'h21);
        run_instr(8'h21, 16'h4021, 0, 0, 0, 0, 1, 0, 8'h00);
        check_eq("ret_12", 32'(pc), 32'h12);

        // Fill the 4-deep stack, then overflow.
        run_instr(8'h12, 16'h3012, 0, 0, 0, 1, 0, 0, 8'h20);
        run_instr(8'h20, 16'h3020, 0, 0, 0, 1, 0, 0, 8'h30);
        run_instr(8'h30, 16'h3030, 0, 0, 0, 1, 0, 0, 8'h50);
        run_instr(8'h50, 16'h3050, 0, 0, 0, 1, 0, 0, 8'h60);
        check_eq("call4", 32'(pc), 32'h60);
        check_eq("call4_err", 32'(err), 0);
        run_instr(8'h60, 16'h3060, 0, 0, 0, 1, 0, 0, 8'h70);
        check_eq("ovf_pc",  32'(pc), 32'h60);
        check_eq("ovf_err", 32'(err), 1);
        check_eq("ovf_h",   32'(halted), 1);
        hammer_halted(4, 8'h60, 1'b1);

        // Reset mid-fetch discards the pending fetch and the pushed return address.
        do_reset();
        run_instr(8'h00, 16'h3000, 0, 0, 0, 1, 0, 0, 8'h33);
        check_eq("call_33", 32'(pc), 32'h33);
        imem_ack = 1'b0;
        @(negedge clk);
        check_eq("mid_wait_req", 32'(imem_req), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_req", 32'(imem_req), 0);
        check_eq("mid_rst_pc",  32'(pc), 32'h00);
        rst = 1'b0;
        last_ir = '0;
        #1;

        // Stack is empty again: ret underflows.
        run_instr(8'h00, 16'h4000, 0, 0, 0, 0, 1, 0, 8'h00);
        check_eq("unf_pc",  32'(pc), 32'h00);
        check_eq("unf_err", 32'(err), 1);
        check_eq("unf_h",   32'(halted), 1);
        hammer_halted(3, 8'h00, 1'b1);
        do_reset();

        // halt beats jmp on the same ex_done.
        run_instr(8'h00, 16'h5000, 0, 0, 1, 0, 0, 1, 8'h77);
        check_eq("hj_pc",  32'(pc), 32'h00);
        check_eq("hj_h",   32'(halted), 1);
        check_eq("hj_err", 32'(err), 0);
        hammer_halted(2, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
